// File: rtl/div_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_arbiter                                                |
// | Description : Round-robin arbiter/sequencer sharing one 32x32 divider    |
// |               between NUM_REQ requesters, with a tagged response channel.|
// |               Option macro: DIV_ARB_ZERO_BYPASS_EN (B==0 answered        |
// |               locally without starting the divider).                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [32*NUM_REQ-1:0]   req_a_i,
  input  logic [32*NUM_REQ-1:0]   req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [31:0]             rsp_quotient_o,
  output logic [31:0]             rsp_remainder_o,
  output logic                    rsp_error_o,
  output logic                    div_start_o,
  output logic [31:0]             div_a_o,
  output logic [31:0]             div_b_o,
  input  logic                    div_ready_i,
  input  logic [31:0]             div_quotient_i,
  input  logic [31:0]             div_remainder_i,
  input  logic                    div_error_i
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     op_a_q, op_a_d;
  logic [31:0]     op_b_q, op_b_d;
  logic [31:0]     quot_q, quot_d;
  logic [31:0]     rem_q, rem_d;
  logic            err_q, err_d;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [31:0]     win_a;
  logic [31:0]     win_b;
  logic            grant;

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant_q) + off) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign win_a = req_a_i[32*winner +: 32];
  assign win_b = req_b_i[32*winner +: 32];

  // Handshake is held quiet while reset is asserted so no grant leaks out.
  assign grant       = (state_q == S_IDLE) && found && !rst_i;
  assign req_ready_o = grant ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          last_grant_d = winner;
          id_d         = winner;
          op_a_d       = win_a;
          op_b_d       = win_b;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (win_b == 32'd0) begin
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = win_a;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        if (div_ready_i) state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Ready falling is the divider's acknowledgement of the start pulse.
        if (!div_ready_i) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (div_ready_i) begin
          quot_d  = div_quotient_i;
          rem_d   = div_remainder_i;
          err_d   = div_error_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
    end
  end

  assign div_start_o     = (state_q == S_ISSUE) && div_ready_i;
  assign div_a_o         = op_a_q;
  assign div_b_o         = op_b_q;
  assign rsp_valid_o     = (state_q == S_RESP);
  assign rsp_id_o        = id_q;
  assign rsp_quotient_o  = quot_q;
  assign rsp_remainder_o = rem_q;
  assign rsp_error_o     = err_q;

endmodule
`default_nettype wire
